// File: rtl/m1553_resp_window.sv
// MIL-STD-1553 bus-controller response-gap monitor: times end-of-transmission to status sync
// and classifies the gap. Optional error statistics are enabled with `M1553_RESP_STATS_EN.
module m1553_resp_window #(
  parameter int MinGapCycles  = 160,
  parameter int MaxGapCycles  = 480,
  parameter int TimeoutCycles = 560,
  localparam int W = $clog2(TimeoutCycles + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_sync_det,
`ifdef M1553_RESP_STATS_EN
  input  logic         i_stats_clear,
  output logic [7:0]   o_err_count,
`endif
  output logic         o_busy,
  output logic         o_resp_ok,
  output logic         o_resp_early,
  output logic         o_resp_late,
  output logic         o_timeout,
  output logic [W-1:0] o_gap
);

  if (MinGapCycles <= 0) begin : g_chk_min
    $fatal(1, "m1553_resp_window: MinGapCycles must be > 0");
  end
  if (MaxGapCycles <= MinGapCycles) begin : g_chk_max
    $fatal(1, "m1553_resp_window: MaxGapCycles must be > MinGapCycles");
  end
  if (TimeoutCycles <= MaxGapCycles) begin : g_chk_tmo
    $fatal(1, "m1553_resp_window: TimeoutCycles must be > MaxGapCycles");
  end

  localparam logic [W-1:0] MIN_C  = W'(MinGapCycles);
  localparam logic [W-1:0] MAX_C  = W'(MaxGapCycles);
  localparam logic [W-1:0] LAST_C = W'(TimeoutCycles - 1);
  localparam logic [W-1:0] TMO_C  = W'(TimeoutCycles);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   gap_q, gap_d;
  logic           busy_q, busy_d;
  logic           ok_q, ok_d;
  logic           early_q, early_d;
  logic           late_q, late_d;
  logic           tmo_q, tmo_d;

  // Abort outranks everything; inside WAIT a fresh start outranks sync, and sync outranks timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    ok_d    = 1'b0;
    early_d = 1'b0;
    late_d  = 1'b0;
    tmo_d   = 1'b0;
    if (i_abort) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_WAIT;
            count_d = '0;
          end
        end
        S_WAIT: begin
          if (i_start) begin
            count_d = '0;
          end else if (i_sync_det) begin
            state_d = S_REPORT;
            gap_d   = count_q;
            if (count_q < MIN_C) begin
              early_d = 1'b1;
            end else if (count_q <= MAX_C) begin
              ok_d = 1'b1;
            end else begin
              late_d = 1'b1;
            end
          end else if (count_q == LAST_C) begin
            state_d = S_REPORT;
            gap_d   = TMO_C;
            tmo_d   = 1'b1;
          end else begin
            count_d = count_q + W'(1);
          end
        end
        S_REPORT: begin
          if (i_start) begin
            state_d = S_WAIT;
            count_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
    busy_d = (state_d == S_WAIT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      early_q <= early_d;
      late_q  <= late_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_resp_ok    = ok_q;
  assign o_resp_early = early_q;
  assign o_resp_late  = late_q;
  assign o_timeout    = tmo_q;
  assign o_gap        = gap_q;

`ifdef M1553_RESP_STATS_EN
  logic [7:0] err_q, err_d;

  // Counts on the same edge the error pulse is registered; clear beats the increment.
  always_comb begin
    err_d = err_q;
    if (i_stats_clear) begin
      err_d = '0;
    end else if ((early_d || late_d || tmo_d) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err_count = err_q;
`endif

endmodule

// File: tb/tb_m1553_resp_window.sv
// Randomized scoreboard bench for m1553_resp_window: the driver pushes expected results,
// a negedge monitor pops and compares whenever a result pulse appears.
module tb_m1553_resp_window;
  localparam int MIN_G = 160;
  localparam int MAX_G = 480;
  localparam int TMO   = 560;
  localparam int W     = $clog2(TMO + 1);

  localparam logic [1:0] K_OK    = 2'd0;
  localparam logic [1:0] K_EARLY = 2'd1;
  localparam logic [1:0] K_LATE  = 2'd2;
  localparam logic [1:0] K_TMO   = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start, i_abort, i_sync_det;
  logic         o_busy, o_resp_ok, o_resp_early, o_resp_late, o_timeout;
  logic [W-1:0] o_gap;
`ifdef M1553_RESP_STATS_EN
  logic         i_stats_clear;
  logic [7:0]   o_err_count;
`endif

  logic [W+1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int model_gap = 0;
  int model_err = 0;

  m1553_resp_window #(
    .MinGapCycles (MIN_G),
    .MaxGapCycles (MAX_G),
    .TimeoutCycles(TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_sync_det   (i_sync_det),
`ifdef M1553_RESP_STATS_EN
    .i_stats_clear(i_stats_clear),
    .o_err_count  (o_err_count),
`endif
    .o_busy       (o_busy),
    .o_resp_ok    (o_resp_ok),
    .o_resp_early (o_resp_early),
    .o_resp_late  (o_resp_late),
    .o_timeout    (o_timeout),
    .o_gap        (o_gap)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, required finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  // helpers
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] classify(input int c);
    if (c >= TMO) return K_TMO;
    if (c < MIN_G) return K_EARLY;
    if (c <= MAX_G) return K_OK;
    return K_LATE;
  endfunction

  // Reference: a measurement whose sync lands at gap c (c >= TMO means none) yields one result.
  task automatic expect_result(input int c);
    logic [1:0] k;
    int g;
    k = classify(c);
    g = (c >= TMO) ? TMO : c;
    exp_q.push_back({k, W'(g)});
    model_gap = g;
    if (k != K_OK && model_err < 255) model_err++;
  endtask

  task automatic check_err(input string name);
`ifdef M1553_RESP_STATS_EN
    check(name, int'(o_err_count), model_err);
`else
    if (name.len() == 0) $display("empty check name");
`endif
  endtask

  // driver: c < 0 means no sync (timeout); restart_at >= 0 re-issues start at that count
  task automatic run_txn(input int c, input int restart_at, input bit restart_sync);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("busy_after_start", int'(o_busy), 1);
    if (restart_at >= 0) begin
      repeat (restart_at) step();
      i_start    = 1'b1;
      i_sync_det = restart_sync;
      step();
      i_start    = 1'b0;
      i_sync_det = 1'b0;
      check("busy_after_restart", int'(o_busy), 1);
    end
    if (c >= 0) begin
      repeat (c) step();
      expect_result(c);
      i_sync_det = 1'b1;
      step();
      i_sync_det = 1'b0;
    end else begin
      expect_result(TMO);
      repeat (TMO) step();
    end
    check_err("err_count");
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      i_sync_det = ($urandom_range(0, 1) == 1);
    end
    if (n > 0) begin
      step();
      i_sync_det = 1'b0;
      check("busy_idle", int'(o_busy), 0);
      check("gap_held", int'(o_gap), model_gap);
    end
  endtask

  task automatic do_abort(input int k, input bit with_sync);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (k) step();
    i_abort    = 1'b1;
    i_sync_det = with_sync;
    step();
    i_abort    = 1'b0;
    i_sync_det = 1'b0;
    check("busy_after_abort", int'(o_busy), 0);
    check("gap_after_abort", int'(o_gap), model_gap);
    repeat (3) step();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    int n;
    logic [W+1:0] e;
    logic [1:0] k_act;
    if (rst_n === 1'b1) begin
      n = int'(o_resp_ok) + int'(o_resp_early) + int'(o_resp_late) + int'(o_timeout);
      if (n != 0) begin
        check("one_hot_result", n, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got gap %0d, required no result", o_gap);
        end else begin
          e = exp_q.pop_front();
          k_act = o_timeout ? K_TMO : o_resp_late ? K_LATE : o_resp_early ? K_EARLY : K_OK;
          check("result_kind", int'(k_act), int'(e[W+1:W]));
          check("result_gap", int'(o_gap), int'(e[W-1:0]));
          check("busy_in_report", int'(o_busy), 0);
        end
      end
    end
  end

  // stimulus
  initial begin
    int mode, c, k;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_sync_det = 1'b0;
`ifdef M1553_RESP_STATS_EN
    i_stats_clear = 1'b0;
`endif
    repeat (3) step();
    check("rst_busy", int'(o_busy), 0);
    check("rst_pulses", int'({o_resp_ok, o_resp_early, o_resp_late, o_timeout}), 0);
    check("rst_gap", int'(o_gap), 0);
    check_err("rst_err");
    rst_n = 1'b1;
    step();

    // directed boundaries
    run_txn(200, -1, 1'b0); idle_gap(2);
    run_txn(159, -1, 1'b0); idle_gap(1);
    run_txn(160, -1, 1'b0); idle_gap(1);
    run_txn(480, -1, 1'b0); idle_gap(1);
    run_txn(481, -1, 1'b0); idle_gap(1);
    run_txn(-1,  -1, 1'b0); idle_gap(1);
    run_txn(559, -1, 1'b0); idle_gap(1);
    run_txn(100, 300, 1'b0); idle_gap(1);
    run_txn(0,   559, 1'b1); idle_gap(1);
    do_abort(50, 1'b1);
    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    check("abort_beats_start", int'(o_busy), 0);
    run_txn(10, -1, 1'b0);
    run_txn(170, -1, 1'b0);
    idle_gap(1);

    // randomized
    for (int t = 0; t < 30; t++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0: run_txn(-1, -1, 1'b0);
        1: do_abort($urandom_range(0, TMO - 1), $urandom_range(0, 1) == 1);
        2: run_txn($urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), $urandom_range(0, 1) == 1);
        3: begin
          k = $urandom_range(0, 5);
          c = (k < 3) ? (MIN_G - 1 + k) : (MAX_G - 3 + k);
          run_txn(c, -1, 1'b0);
        end
        default: run_txn($urandom_range(0, TMO - 1), -1, 1'b0);
      endcase
      if (mode != 1) idle_gap($urandom_range(0, 3));
    end
    idle_gap(1);

`ifdef M1553_RESP_STATS_EN
    i_stats_clear = 1'b1;
    step();
    i_stats_clear = 1'b0;
    model_err = 0;
    check_err("stats_clear");
    run_txn(-1, -1, 1'b0);
    run_txn(-1, -1, 1'b0);
    run_txn(-1, -1, 1'b0);
    run_txn(300, -1, 1'b0);
    idle_gap(1);
    check_err("three_timeouts");
    for (int i = 0; i < 300; i++) begin
      run_txn($urandom_range(0, 8), -1, 1'b0);
    end
    idle_gap(1);
    check("err_saturated", int'(o_err_count), 255);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (5) step();
    expect_result(5);
    i_sync_det    = 1'b1;
    i_stats_clear = 1'b1;
    step();
    i_sync_det    = 1'b0;
    i_stats_clear = 1'b0;
    model_err = 0;
    check_err("clear_beats_incr");
    idle_gap(1);
`endif

    // asynchronous reset mid-measurement
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (100) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(o_busy), 0);
    check("arst_pulses", int'({o_resp_ok, o_resp_early, o_resp_late, o_timeout}), 0);
    check("arst_gap", int'(o_gap), 0);
    model_gap = 0;
    model_err = 0;
    check_err("arst_err");
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
